// File: rtl/btn_pkg.sv
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared types and counter-width helpers for the push-button
//                conditioner (channel FSM states, counter sizing).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int CNT_W_MIN = 1;

  // A counter that must reach cycles-1 needs $clog2(cycles) bits, never fewer than one.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? CNT_W_MIN : $clog2(cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce_cell.sv
// ============================================================================
//  Module      : btn_debounce_cell
//  Description : One button channel: 2-flop synchroniser, debounce FSM, hold
//                counter and registered press/release/long pulses. Auto-repeat
//                is built only when BTN_CONDITIONER_AUTO_REPEAT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DCNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int HCNT_W = cnt_width(LONG_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CYCLES - 1);

  logic              meta_q, meta_d;
  logic              sync_q, sync_d;
  btn_state_e        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
  localparam int RCNT_W = cnt_width(REPEAT_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
`else
  logic unused_repeat_cycles;
  assign unused_repeat_cycles = ^REPEAT_CYCLES;
`endif

  always_comb begin
    meta_d      = btn_raw;
    sync_d      = meta_q;
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
    rcnt_d      = rcnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (sync_q) begin
          state_d = ST_PRESS_WAIT;
          dcnt_d  = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d     = ST_HELD;
          press_d     = 1'b1;
          level_d     = 1'b1;
          hcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end

      ST_HELD: begin
        if (hcnt_q != HCNT_LAST) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
        if ((hcnt_q == HCNT_LAST) && !long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
        if (!sync_q) begin
          state_d = ST_RELEASE_WAIT;
          dcnt_d  = '0;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
          rcnt_d  = '0;
        end else if (long_done_q) begin
          // Repeat period starts the cycle after the long pulse.
          if (rcnt_q == RCNT_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
`endif
        end
      end

      ST_RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = ST_HELD;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q      <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
      rcnt_q      <= '0;
`endif
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef BTN_CONDITIONER_AUTO_REPEAT_EN
      rcnt_q      <= rcnt_d;
`endif
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
//  Module      : btn_conditioner
//  Description : NUM_BTN independent push-button conditioning channels.
//                Optional auto-repeat: BTN_CONDITIONER_AUTO_REPEAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int REPEAT_CYCLES   = 20000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_cell (
      .clock         (clock),
      .reset         (reset),
      .btn_raw       (btn_raw[i]),
      .btn_level     (btn_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

`default_nettype wire
